stack_sequencer: RTL and testbench

//   Control FSM for the hardware stack. Sits between the instruction decoder and
//   the stack-pointer / memory-stack pair, and turns PUSH, POP and PEEK requests

---
 rtl/stack_sequencer_if.sv | 35 +++
 rtl/stack_sequencer.sv | 139 +++++++++++++
 tb/tb_stack_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : stack_sequencer_if                                          |
// | Brief  : Request/strobe bundle between the instruction decoder and   |
// |          the stack sequencer.                                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface stack_sequencer_if #(
  parameter int DEPTH_MAX = 65536
);
  localparam int DW = $clog2(DEPTH_MAX + 1);

  logic          i_req;
  logic [1:0]    i_op;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [2:0]    o_sp_ctrl;
  logic          o_mem_w;
  logic          o_mem_drive_n;
  logic [DW-1:0] o_depth;

  // Decoder side: issues requests, observes the strobes
  modport master (
    output i_req, i_op,
    input  o_busy, o_done, o_err, o_sp_ctrl, o_mem_w, o_mem_drive_n, o_depth
  );

  // Sequencer side
  modport slave (
    input  i_req, i_op,
    output o_busy, o_done, o_err, o_sp_ctrl, o_mem_w, o_mem_drive_n, o_depth
  );
endinterface
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : stack_sequencer                                             |
// | Brief  : Control FSM for the hardware stack. Turns PUSH/POP/PEEK     |
// |          requests into SP inc/dec, memory write and bus-drive        |
// |          strobes, and tracks depth with overflow/underflow errors.   |
// | Rev    : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
// o_sp_ctrl encoding: 3'b001 = SP+1, 3'b010 = SP-1, 3'b000 = hold,
// bit [2] = SP drives bus (never used by this sequencer).
module stack_sequencer #(
  parameter int DEPTH_MAX = 65536
) (
  input  wire logic          i_clock,
  input  wire logic          i_reset,
  stack_sequencer_if.slave   bus
);
  localparam int DW = $clog2(DEPTH_MAX + 1);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [2:0] SP_HOLD = 3'b000;
  localparam logic [2:0] SP_INC  = 3'b001;
  localparam logic [2:0] SP_DEC  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_WR  = 3'd1,
    S_PUSH_INC = 3'd2,
    S_POP_DEC  = 3'd3,
    S_POP_RD   = 3'd4,
    S_PEEK_RD  = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] depth_q, depth_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [2:0]    sp_ctrl_q, sp_ctrl_d;
  logic          mem_w_q, mem_w_d;
  logic          drive_n_q, drive_n_d;

  // Next state, latched op and depth; PEEK shares POP_DEC for its SP-1 step
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    depth_d = depth_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req && (bus.i_op != OP_NOP)) begin
          op_d = bus.i_op;
          if (bus.i_op == OP_PUSH) begin
            state_d = (depth_q == DW'(DEPTH_MAX)) ? S_ERR : S_PUSH_WR;
          end else if (depth_q == '0) begin
            state_d = S_ERR;
          end else begin
            state_d = S_POP_DEC;
            if (bus.i_op == OP_POP) depth_d = depth_q - DW'(1);
          end
        end
      end
      S_PUSH_WR: begin
        state_d = S_PUSH_INC;
        depth_d = depth_q + DW'(1);
      end
      S_PUSH_INC: state_d = S_DONE;
      S_POP_DEC:  state_d = (op_q == OP_PEEK) ? S_PEEK_RD : S_POP_RD;
      S_POP_RD:   state_d = S_DONE;
      S_PEEK_RD:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE) || (state_d == S_ERR);
    err_d     = (state_d == S_ERR);
    mem_w_d   = (state_d == S_PUSH_WR);
    sp_ctrl_d = SP_HOLD;
    drive_n_d = 1'b1;
    case (state_d)
      S_PUSH_INC: sp_ctrl_d = SP_INC;
      S_POP_DEC:  sp_ctrl_d = SP_DEC;
      S_POP_RD:   drive_n_d = 1'b0;
      S_PEEK_RD:  drive_n_d = 1'b0;
      S_DONE: begin
        // Keep read data on the bus alongside o_done; PEEK restores SP here
        if (op_d != OP_PUSH) drive_n_d = 1'b0;
        if (op_d == OP_PEEK) sp_ctrl_d = SP_INC;
      end
      default: ;
    endcase
  end

  // State, depth and registered outputs; reset aborts any operation at once
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      depth_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sp_ctrl_q <= SP_HOLD;
      mem_w_q   <= 1'b0;
      drive_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      depth_q   <= depth_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sp_ctrl_q <= sp_ctrl_d;
      mem_w_q   <= mem_w_d;
      drive_n_q <= drive_n_d;
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_sp_ctrl     = sp_ctrl_q;
  assign bus.o_mem_w       = mem_w_q;
  assign bus.o_mem_drive_n = drive_n_q;
  assign bus.o_depth       = depth_q;
endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_stack_sequencer                                          |
// | Brief  : Scoreboard bench for stack_sequencer with a behavioural     |
// |          SP / memory-stack pair driven by the DUT strobes.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_stack_sequencer;
  localparam int DMAX = 4;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [15:0] data;
    logic [2:0]  depth;
    int          lat;
    int          wr;
    int          inc;
    int          dec;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   passes = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stack_sequencer_if #(.DEPTH_MAX(DMAX)) sif ();
  stack_sequencer #(.DEPTH_MAX(DMAX)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (sif.slave)
  );

  // Behavioural SP and memory stack; the SP is deliberately not reset
  logic [15:0] mem [0:15];
  logic [3:0]  sp = 4'd5;
  logic [15:0] wdata;
  logic [15:0] rdata;
  always @(posedge clk) begin
    if (sif.o_mem_w) mem[sp] <= wdata;
    if (sif.o_sp_ctrl[1:0] == 2'b01) sp <= sp + 4'd1;
    else if (sif.o_sp_ctrl[1:0] == 2'b10) sp <= sp - 4'd1;
  end
  assign rdata = sif.o_mem_drive_n ? 16'h0000 : mem[sp];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic err, input logic cd, input logic [15:0] d,
                              input logic [2:0] dep, input int lat, input int wr,
                              input int inc, input int dec);
    exp_t e;
    e.err = err; e.chk_data = cd; e.data = d; e.depth = dep;
    e.lat = lat; e.wr = wr; e.inc = inc; e.dec = dec; e.acc = 0;
    return e;
  endfunction

  // Monitor: accumulate strobes, check invariants, score each o_done
  int wr_cnt = 0, inc_cnt = 0, dec_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0; inc_cnt = 0; dec_cnt = 0;
    end else begin
      if (sif.o_mem_w) wr_cnt++;
      if (sif.o_sp_ctrl[1:0] == 2'b01) inc_cnt++;
      if (sif.o_sp_ctrl[1:0] == 2'b10) dec_cnt++;
      if (sif.o_mem_w && !sif.o_mem_drive_n) chk("write_vs_drive", 1, 0);
      if (sif.o_sp_ctrl[2] && !sif.o_mem_drive_n) chk("sp_vs_mem_drive", 1, 0);
      if (sif.o_err && !sif.o_done) chk("err_without_done", 1, 0);
      if (sif.o_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("err", 32'(sif.o_err), 32'(e.err));
          chk("depth", 32'(sif.o_depth), 32'(e.depth));
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("mem_w_count", wr_cnt, e.wr);
          chk("sp_inc_count", inc_cnt, e.inc);
          chk("sp_dec_count", dec_cnt, e.dec);
          if (e.chk_data) chk("bus_data", 32'(rdata), 32'(e.data));
        end
        wr_cnt = 0; inc_cnt = 0; dec_cnt = 0;
      end
    end
  end

  // Issue one request, optionally poking i_req while busy, wait for o_done
  task automatic issue(input logic [1:0] op, input logic [15:0] d, input exp_t e,
                       input bit poke);
    bit seen;
    @(posedge clk); #1;
    sif.i_req = 1'b1; sif.i_op = op; wdata = d;
    @(posedge clk); #1;
    sif.i_req = 1'b0; sif.i_op = 2'b00;
    e.acc = cyc;
    q.push_back(e);
    chk("busy_after_accept", 32'(sif.o_busy), 1);
    if (poke) begin
      sif.i_req = 1'b1; sif.i_op = OP_POP;
      @(posedge clk); #1;
      sif.i_req = 1'b0; sif.i_op = 2'b00;
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (sif.o_done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  logic [3:0] sp0;
  initial begin
    rst = 1'b1; sif.i_req = 1'b0; sif.i_op = 2'b00; wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(sif.o_busy), 0);
    chk("rst_done", 32'(sif.o_done), 0);
    chk("rst_err", 32'(sif.o_err), 0);
    chk("rst_sp_ctrl", 32'(sif.o_sp_ctrl), 0);
    chk("rst_mem_w", 32'(sif.o_mem_w), 0);
    chk("rst_drive_n", 32'(sif.o_mem_drive_n), 1);
    chk("rst_depth", 32'(sif.o_depth), 0);

    // Single push then pop back to empty
    issue(OP_PUSH, 16'hBEEF, mk(0, 0, 16'h0, 3'd1, 3, 1, 1, 0), 0);
    issue(OP_POP,  16'h0,    mk(0, 1, 16'hBEEF, 3'd0, 3, 0, 0, 1), 0);

    // LIFO order, SP returns to start, request while busy ignored
    sp0 = sp;
    issue(OP_PUSH, 16'h1111, mk(0, 0, 16'h0, 3'd1, 3, 1, 1, 0), 0);
    issue(OP_PUSH, 16'h2222, mk(0, 0, 16'h0, 3'd2, 3, 1, 1, 0), 1);
    issue(OP_POP,  16'h0,    mk(0, 1, 16'h2222, 3'd1, 3, 0, 0, 1), 0);
    issue(OP_POP,  16'h0,    mk(0, 1, 16'h1111, 3'd0, 3, 0, 0, 1), 0);
    chk("sp_restored", 32'(sp), 32'(sp0));

    // Underflow on empty
    issue(OP_POP,  16'h0, mk(1, 0, 16'h0, 3'd0, 1, 0, 0, 0), 0);
    issue(OP_PEEK, 16'h0, mk(1, 0, 16'h0, 3'd0, 1, 0, 0, 0), 0);

    // Fill to DEPTH_MAX, overflow, peek top, drain
    for (int i = 1; i <= DMAX; i++)
      issue(OP_PUSH, 16'hA000 + 16'(i), mk(0, 0, 16'h0, 3'(i), 3, 1, 1, 0), 0);
    issue(OP_PUSH, 16'hA005, mk(1, 0, 16'h0, 3'd4, 1, 0, 0, 0), 0);
    issue(OP_PEEK, 16'h0,    mk(0, 1, 16'hA004, 3'd4, 3, 0, 1, 1), 0);
    for (int i = DMAX; i >= 1; i--)
      issue(OP_POP, 16'h0, mk(0, 1, 16'hA000 + 16'(i), 3'(i - 1), 3, 0, 0, 1), 0);

    // Reset while in POP_DEC aborts with no o_done
    issue(OP_PUSH, 16'h7777, mk(0, 0, 16'h0, 3'd1, 3, 1, 1, 0), 0);
    @(posedge clk); #1;
    sif.i_req = 1'b1; sif.i_op = OP_POP;
    @(posedge clk); #1;
    sif.i_req = 1'b0; sif.i_op = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(sif.o_busy), 0);
    chk("abort_depth", 32'(sif.o_depth), 0);
    chk("abort_done", 32'(sif.o_done), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_abort_busy", 32'(sif.o_busy), 0);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
`default_nettype wire
